// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline control for the six-stage core: stall chain, per-stage valid bits,
// trap-redirect sequencing and stall/flush performance counters.
module ysyx_041461_pipe_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IF_fire,
  input  logic                   IF2_busy,
  input  logic                   MEM_busy,
  input  logic                   ID_jump,
  input  logic                   CD_ID_conflict,
  input  logic                   CD_EXE_conflict,
  input  logic                   CD_MEM_conflict,
  input  logic                   CD_IF_trap,
  input  logic                   CD_IF2_trap,
  input  logic                   CD_ID_trap,
  input  logic                   CD_EXE_trap,
  input  logic                   CD_MEM_trap,
  input  logic                   WB_trap,
  output logic                   IF2_valid,
  output logic                   ID_valid,
  output logic                   EXE_valid,
  output logic                   MEM_valid,
  output logic                   WB_valid,
  output logic                   IF_stall,
  output logic                   IF2_stall,
  output logic                   ID_stall,
  output logic                   EXE_stall,
  output logic                   MEM_stall,
  output logic                   trap_redirect,
  output logic [STALL_CNT_W-1:0] conflict_stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Stage index: 0 = IF2, 1 = ID, 2 = EXE, 3 = MEM, 4 = WB
  logic [4:0] valid_q, valid_d;
  logic [3:0] stall_vec;
  logic [3:0] squash_vec;
  logic [3:0] feed_vec;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic in_run;
  logic any_conflict;
  logic jmp;
  logic wb_feed;

  assign in_run       = (state_q == ST_RUN);
  assign any_conflict = CD_ID_conflict | CD_EXE_conflict | CD_MEM_conflict;

  always_comb begin
    MEM_stall = 1'b0;
    EXE_stall = 1'b0;
    ID_stall  = 1'b0;
    IF2_stall = 1'b0;
    IF_stall  = 1'b0;
    if (in_run) begin
      MEM_stall = MEM_busy | CD_MEM_conflict;
      EXE_stall = CD_EXE_conflict | MEM_stall;
      ID_stall  = CD_ID_conflict | EXE_stall;
      IF2_stall = IF2_busy | ID_stall;
      IF_stall  = IF2_stall | CD_IF_trap;
    end
  end

  assign stall_vec = {MEM_stall, EXE_stall, ID_stall, IF2_stall};

  // A stalled ID must not redirect fetch; its branch resolves again later.
  assign jmp = in_run & ID_jump & valid_q[1] & ~ID_stall;

  assign squash_vec = {CD_MEM_trap, CD_EXE_trap, CD_ID_trap, CD_IF2_trap | jmp};

  assign feed_vec[0] = IF_fire & ~CD_IF_trap;
  assign feed_vec[1] = valid_q[0] & ~stall_vec[0] & ~CD_IF2_trap & ~jmp;
  assign feed_vec[2] = valid_q[1] & ~stall_vec[1] & ~CD_ID_trap;
  assign feed_vec[3] = valid_q[2] & ~stall_vec[2] & ~CD_EXE_trap;
  assign wb_feed     = valid_q[3] & ~stall_vec[3] & ~CD_MEM_trap;

  // Squash beats hold beats advance; the redirect cycle clears everything.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage_valid
      assign valid_d[gi] = in_run & ~squash_vec[gi] &
                           (stall_vec[gi] ? valid_q[gi] : feed_vec[gi]);
    end
  endgenerate

  assign valid_d[4] = in_run & wb_feed;

  always_comb begin
    state_d       = state_q;
    trap_redirect = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (valid_q[4] & WB_trap) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        trap_redirect = 1'b1;
        state_d       = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_run & any_conflict & ~(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (jmp | ~in_run) begin
      flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      valid_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign IF2_valid          = valid_q[0];
  assign ID_valid           = valid_q[1];
  assign EXE_valid          = valid_q[2];
  assign MEM_valid          = valid_q[3];
  assign WB_valid           = valid_q[4];
  assign conflict_stall_cnt = stall_cnt_q;
  assign flush_cnt          = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// Scoreboard bench for ysyx_041461_pipe_ctrl: a stage-array reference model
// predicts each cycle's outputs, a separate monitor pops and compares them.
module tb_ysyx_041461_pipe_ctrl;

  localparam int SW = 4;
  localparam int FW = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam int FMOD = 1 << FW;

  logic clk = 1'b0;
  logic rst;
  logic IF_fire, IF2_busy, MEM_busy, ID_jump;
  logic CD_ID_conflict, CD_EXE_conflict, CD_MEM_conflict;
  logic CD_IF_trap, CD_IF2_trap, CD_ID_trap, CD_EXE_trap, CD_MEM_trap;
  logic WB_trap;
  logic IF2_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
  logic IF_stall, IF2_stall, ID_stall, EXE_stall, MEM_stall;
  logic trap_redirect;
  logic [SW-1:0] conflict_stall_cnt;
  logic [FW-1:0] flush_cnt;

  always #5 clk = ~clk;

  ysyx_041461_pipe_ctrl #(.STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
    .clk(clk), .rst(rst),
    .IF_fire(IF_fire), .IF2_busy(IF2_busy), .MEM_busy(MEM_busy), .ID_jump(ID_jump),
    .CD_ID_conflict(CD_ID_conflict), .CD_EXE_conflict(CD_EXE_conflict),
    .CD_MEM_conflict(CD_MEM_conflict),
    .CD_IF_trap(CD_IF_trap), .CD_IF2_trap(CD_IF2_trap), .CD_ID_trap(CD_ID_trap),
    .CD_EXE_trap(CD_EXE_trap), .CD_MEM_trap(CD_MEM_trap), .WB_trap(WB_trap),
    .IF2_valid(IF2_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
    .MEM_valid(MEM_valid), .WB_valid(WB_valid),
    .IF_stall(IF_stall), .IF2_stall(IF2_stall), .ID_stall(ID_stall),
    .EXE_stall(EXE_stall), .MEM_stall(MEM_stall),
    .trap_redirect(trap_redirect),
    .conflict_stall_cnt(conflict_stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    int       cyc;
    logic [4:0] stall;  // bit 0 = IF .. bit 4 = MEM
    logic       redir;
    logic [4:0] valid;  // bit 0 = IF2 .. bit 4 = WB
    int       scnt;
    int       fcnt;
  } exp_t;

  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  logic [4:0] mv;
  logic       mredir;
  int         mscnt, mfcnt;
  logic [4:0] es;
  logic       ejmp;

  function automatic void chk(string name, int c, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
    end
  endfunction

  // Stall of a stage is any cause at that stage or any older stage.
  task automatic model_comb();
    logic [4:0] cause;
    logic s;
    cause = {MEM_busy | CD_MEM_conflict, CD_EXE_conflict, CD_ID_conflict, IF2_busy, CD_IF_trap};
    s = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      s = s | cause[k];
      es[k] = !mredir && s;
    end
    ejmp = !mredir && ID_jump && mv[1] && !es[2];
  endtask

  task automatic model_edge();
    logic [3:0] trapv;
    logic [4:0] nv;
    logic       inc;
    if (rst) begin
      mv = '0; mredir = 1'b0; mscnt = 0; mfcnt = 0;
      return;
    end
    if (mredir) begin
      mv = '0; mredir = 1'b0; mfcnt = (mfcnt + 1) % FMOD;
      return;
    end
    trapv = {CD_MEM_trap, CD_EXE_trap, CD_ID_trap, CD_IF2_trap};
    for (int k = 0; k < 5; k++) begin
      if (k == 0) inc = IF_fire && !CD_IF_trap;
      else        inc = mv[k-1] && !es[k] && !trapv[k-1] && !(k == 1 && ejmp);
      if (k == 4)                          nv[k] = inc;
      else if (trapv[k] || (k == 0 && ejmp)) nv[k] = 1'b0;
      else if (es[k+1])                    nv[k] = mv[k];
      else                                 nv[k] = inc;
    end
    if (CD_ID_conflict || CD_EXE_conflict || CD_MEM_conflict)
      mscnt = (mscnt + 1 > SMAX) ? SMAX : mscnt + 1;
    if (ejmp) mfcnt = (mfcnt + 1) % FMOD;
    mredir = mv[4] && WB_trap;
    mv = nv;
  endtask

  function automatic logic rnd(int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic set_inputs(int mode);
    {IF_fire, IF2_busy, MEM_busy, ID_jump, CD_ID_conflict, CD_EXE_conflict,
     CD_MEM_conflict, CD_IF_trap, CD_IF2_trap, CD_ID_trap, CD_EXE_trap,
     CD_MEM_trap, WB_trap} = '0;
    rst = 1'b0;
    case (mode)
      0: IF_fire = 1'b1;
      1: begin IF_fire = 1'b1; CD_EXE_conflict = 1'b1; end
      2: begin IF_fire = 1'b1; ID_jump = 1'b1; end
      3: begin IF_fire = 1'b1; ID_jump = 1'b1; CD_ID_conflict = 1'b1; end
      4, 5: begin
        IF_fire = 1'b1; WB_trap = 1'b1;
        {CD_IF_trap, CD_IF2_trap, CD_ID_trap, CD_EXE_trap, CD_MEM_trap} = {5{mv[4]}};
        MEM_busy = mv[4];
        rst = (mode == 5) && mredir;
      end
      default: begin
        IF_fire = rnd(80); IF2_busy = rnd(15); MEM_busy = rnd(15); ID_jump = rnd(25);
        CD_ID_conflict = rnd(10); CD_EXE_conflict = rnd(10); CD_MEM_conflict = rnd(10);
        CD_IF_trap = rnd(5); CD_IF2_trap = rnd(5); CD_ID_trap = rnd(5);
        CD_EXE_trap = rnd(5); CD_MEM_trap = rnd(5); WB_trap = rnd(10);
        rst = mredir ? rnd(30) : rnd(0) | ($urandom_range(299) == 0);
      end
    endcase
  endtask

  task automatic run_phase(int mode, int ncyc);
    exp_t e;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      set_inputs(mode);
      model_comb();
      e.cyc = cyc; e.stall = es; e.redir = mredir; e.valid = mv;
      e.scnt = mscnt; e.fcnt = mfcnt;
      exp_q.push_back(e);
      @(posedge clk);
      model_edge();
      cyc++;
    end
  endtask

  initial begin
    {IF_fire, IF2_busy, MEM_busy, ID_jump, CD_ID_conflict, CD_EXE_conflict,
     CD_MEM_conflict, CD_IF_trap, CD_IF2_trap, CD_ID_trap, CD_EXE_trap,
     CD_MEM_trap, WB_trap} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    mv = '0; mredir = 1'b0; mscnt = 0; mfcnt = 0;
    run_phase(0, 8);
    run_phase(1, 2);
    run_phase(0, 4);
    run_phase(2, 40);
    run_phase(3, 20);
    run_phase(0, 6);
    run_phase(4, 6);
    run_phase(0, 6);
    run_phase(5, 6);
    run_phase(0, 6);
    run_phase(6, 1500);
    @(negedge clk);
    #2;
    chk("scoreboard_drained", cyc, exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Monitor: every cycle the DUT presents a full output set; compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("cyc %0d stall=%b valid=%b redir=%b scnt=%0d fcnt=%0d", e.cyc,
                 {MEM_stall, EXE_stall, ID_stall, IF2_stall, IF_stall},
                 {WB_valid, MEM_valid, EXE_valid, ID_valid, IF2_valid},
                 trap_redirect, conflict_stall_cnt, flush_cnt);
        chk("stall", e.cyc, int'({MEM_stall, EXE_stall, ID_stall, IF2_stall, IF_stall}), int'(e.stall));
        chk("valid", e.cyc, int'({WB_valid, MEM_valid, EXE_valid, ID_valid, IF2_valid}), int'(e.valid));
        chk("trap_redirect", e.cyc, int'(trap_redirect), int'(e.redir));
        chk("conflict_stall_cnt", e.cyc, int'(conflict_stall_cnt), e.scnt);
        chk("flush_cnt", e.cyc, int'(flush_cnt), e.fcnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
